// File: rtl/mms_stream_selector.sv
// Serial max/min selector: scans a COUNT-element frame off a valid/ready stream and
// returns the winning value and its index. Define MMS_FLUSH_EN to add an early-end flush input.
module mms_stream_selector #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MMS_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [IDX_W-1:0] out_index
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               sel_reg, sel_next;
  logic [WIDTH-1:0]   best_reg, best_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               accept;
  logic               flush_w;
  logic               replace;

`ifdef MMS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready   = (state_reg != DONE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = best_reg;
  assign out_index  = idx_reg;
  assign accept     = in_valid && in_ready;

  // Strict comparison: ties keep the earlier element.
  assign replace = sel_reg ? (in_data < best_reg) : (in_data > best_reg);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sel_next   = sel_reg;
    best_next  = best_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          sel_next   = select;
          best_next  = in_data;
          idx_next   = '0;
          count_next = CNT_W'(1);
          state_next = ((COUNT == 1) || flush_w) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (replace) begin
            best_next = in_data;
            idx_next  = IDX_W'(count_reg);
          end
          count_next = count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(COUNT - 1))
            state_next = DONE;
        end
        // The beat accepted alongside a flush has already been folded in above.
        if (flush_w)
          state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      sel_reg   <= 1'b0;
      best_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sel_reg   <= sel_next;
      best_reg  <= best_next;
      idx_reg   <= idx_next;
    end
  end

endmodule

// File: tb/tb_mms_stream_selector.sv
// Scoreboard bench for mms_stream_selector: directed frames push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_mms_stream_selector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       select = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic [2:0] out_index;
`ifdef MMS_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  mms_stream_selector #(.WIDTH(8), .COUNT(8), .IDX_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MMS_FLUSH_EN
    .flush(flush),
`endif
    .select(select),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_index(out_index)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive point: just after the rising edge, so DUT outputs reflect the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input bit bubble);
    int n;
    if (bubble) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("beat_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", int'(out_result), int'(e[10:3]));
        chk("index", int'(out_index), int'(e[2:0]));
        $display("result value=%0d index=%0d", out_result, out_index);
      end
    end
  end

  initial begin
    int n;
    // Reset state.
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_result", int'(out_result), 0);
    chk("rst_out_index", int'(out_index), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Max frame with a tie, back-to-back beats.
    select = 1'b0;
    exp_q.push_back({8'd9, 3'd1});
    beat(8'd3, 0); beat(8'd9, 0); beat(8'd1, 0); beat(8'd9, 0);
    beat(8'd7, 0); beat(8'd0, 0); beat(8'd2, 0); beat(8'd5, 0);
    chk("f1_out_valid", int'(out_valid), 1);
    chk("f1_in_ready_done", int'(in_ready), 0);
    tick();
    chk("f1_out_valid_1cyc", int'(out_valid), 0);
    chk("f1_in_ready_idle", int'(in_ready), 1);

    // Min frame with bubbles.
    select = 1'b1;
    exp_q.push_back({8'd4, 3'd4});
    beat(8'd200, 1); beat(8'd17, 1); beat(8'd255, 1); beat(8'd17, 1);
    beat(8'd4, 1);   beat(8'd4, 1);  beat(8'd90, 1);  beat(8'd100, 1);
    tick();

    // Select latched on the first beat only.
    select = 1'b0;
    exp_q.push_back({8'd80, 3'd7});
    beat(8'd10, 0);
    select = 1'b1;
    for (int k = 2; k <= 8; k++) beat(8'(k * 10), 0);
    tick();
    select = 1'b0;

    // Output backpressure.
    out_ready = 1'b0;
    exp_q.push_back({8'd7, 3'd7});
    for (int k = 0; k < 8; k++) beat(8'(k), 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_result", int'(out_result), 7);
      chk("bp_out_index", int'(out_index), 7);
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    exp_q.push_back({8'd99, 3'd0});
    beat(8'd99, 0);
    for (int k = 1; k < 8; k++) beat(8'(k), 0);
    tick();

    // Reset mid-frame discards the partial frame.
    beat(8'd50, 0); beat(8'd60, 0); beat(8'd200, 0); beat(8'd10, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_result", int'(out_result), 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({8'd8, 3'd7});
    for (int k = 1; k <= 8; k++) beat(8'(k), 0);
    tick();

`ifdef MMS_FLUSH_EN
    // Flush with a concurrent beat ends the frame after including that beat.
    exp_q.push_back({8'd12, 3'd1});
    beat(8'd5, 0); beat(8'd12, 0); beat(8'd3, 0);
    flush = 1'b1;
    beat(8'd11, 0);
    flush = 1'b0;
    chk("flush_out_valid", int'(out_valid), 1);
    tick();
    // Flush alone in IDLE yields nothing.
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_idle_no_valid", int'(out_valid), 0);
    end
    flush = 1'b0;
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mms_stream_selector.md
Name: mms_stream_selector

Overview:
- Serial-input counterpart of the parallel max/min selector tree.
- Consumes a frame of COUNT unsigned numbers, one per accepted beat over a valid/ready stream.
- Tracks the running max or min and the index of the winning element.
- Presents one result per frame on a valid/ready output, so a producer can feed numbers serially instead of presenting all 8 in parallel.

Parameters:
- WIDTH, 8: data width of each number and of the result.
- COUNT, 8: numbers per frame, minimum 1.
- IDX_W, 3: width of the index output; must satisfy 2**IDX_W >= COUNT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- select  input  1  0 = max, 1 = min; sampled only on a frame's first accepted beat.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  unsigned number.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  selected max/min value.
- out_index  output  IDX_W  position (0..COUNT-1) of the winning element within the frame.

Behaviour:
- Single clock. Reset is asynchronous and active-low; the clock is clk and the reset is rst_n.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_result = 0
  - out_index = 0
  - internal count = 0
  - latched select = 0
- Accept event: in_valid && in_ready on a rising edge. Output handshake: out_valid && out_ready.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On accept:
    - latch select into sel_q
    - best <= in_data, best_idx <= 0, count <= 1
    - go to ACCUM, or to DONE if COUNT == 1
  - ACCUM: in_ready = 1. On accept of element i (= count):
    - sel_q = 0: replace best only if in_data > best.
    - sel_q = 1: replace best only if in_data < best.
    - On replace: best_idx <= i.
    - Ties never replace; the earliest index wins, matching the parallel selector's tie rule.
    - count <= count + 1. When count reaches COUNT on this beat, go to DONE.
    - No accept in a cycle: hold all state.
  - DONE: in_ready = 0, out_valid = 1.
    - out_result and out_index are registered and stable until the output handshake.
    - On the output handshake, go to IDLE and clear count. Input is not accepted in that same cycle.
- select changes after the first beat of a frame are ignored until the next frame's first beat.
- Comparisons are unsigned on WIDTH bits.
- Latency: out_valid rises on the cycle after the COUNT-th accept.
- Throughput: COUNT accept cycles plus 1 handoff cycle per frame.
- in_valid deasserting mid-frame (bubbles) is legal. The frame continues when beats resume.
- out_ready held high while in DONE: one cycle of out_valid, then IDLE.
- Reset asserted mid-frame or in DONE immediately restores all reset values. The partial frame is discarded.
- count is wide enough to hold COUNT (clog2(COUNT+1) bits).

Optional Feature:
- Macro: MMS_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush high in ACCUM ends the frame early: go to DONE with the current best/best_idx.
  - If flush and an accept occur in the same cycle, the accepted beat is compared first and included, then go to DONE.
  - flush in IDLE with no accept is ignored (no empty results).
  - flush in IDLE together with an accept yields a one-element frame.
  - flush in DONE is ignored.
- Undefined: no flush port; frames always contain exactly COUNT elements.

Test Plan:
- Reset, then max frame: select = 0, stream 3,9,1,9,7,0,2,5 back-to-back, out_ready = 1 → out_result = 9, out_index = 1 (tie keeps earliest); out_valid high exactly 1 cycle; in_ready low that cycle.
- Min frame with bubbles: select = 1, stream 200,17,255,17,4,4,90,100 with in_valid low on alternate cycles → out_result = 4, out_index = 4.
- Select latched: select = 0 on beat 0, switched to 1 on beat 1, stream 10,20,30,40,50,60,70,80 → out_result = 80, out_index = 7.
- Output backpressure: complete a frame (max of 0..7 = 7), hold out_ready = 0 for 5 cycles while in_valid = 1 with 99 → out_valid stays 1, result 7/7 stable, in_ready = 0, 99 not consumed; then out_ready = 1 → IDLE, and the next frame starts with 99 at index 0.
- Reset mid-frame: after 4 beats, pulse rst_n low → out_valid = 0, in_ready = 1; a fresh 8-beat frame 1..8 (max) gives 8/7, unaffected by the discarded beats.
- MMS_FLUSH_EN: select = 0, stream 5,12,3, flush together with beat 3 = 11 → out_result = 12, out_index = 1; flush alone in IDLE → no out_valid.
